// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_param
// Description : Parametrised register file, two registered read ports, one
//               write port, valid/ready request handshake, optional hardwired
//               zero register and a sequential soft-clear engine.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] read_port_1,
    input  logic [ADDR_W-1:0] read_port_2,
    input  logic [ADDR_W-1:0] write_port_1,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    output logic              rd_valid,
    output logic              busy,
    output logic              err
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0]        c_op_read  = 2'b00;
    localparam logic [1:0]        c_op_write = 2'b01;
    localparam logic [1:0]        c_op_clear = 2'b10;
    localparam logic [1:0]        c_op_ill   = 2'b11;
    localparam logic [ADDR_W-1:0] c_last     = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_rd1;
    logic [DATA_W-1:0]   r_rd2;
    logic                r_rd_valid;
    logic                r_err;

    logic                w_accept;
    logic                w_zero_wr;
    logic                w_wr_en;
    logic [DATA_W-1:0]   w_rd1;
    logic [DATA_W-1:0]   w_rd2;

    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_CLEAR);
    assign w_accept  = req_valid && req_ready;

    // Writes aimed at the hardwired zero register are dropped and flagged.
    assign w_zero_wr = (ZERO_REG != 0) && (write_port_1 == '0);
    assign w_wr_en   = w_accept && (req_op == c_op_write) && !w_zero_wr;

    // Address 0 reads as zero when the hardwired zero register is enabled.
    assign w_rd1 = ((ZERO_REG != 0) && (read_port_1 == '0)) ? '0 : r_mem[read_port_1];
    assign w_rd2 = ((ZERO_REG != 0) && (read_port_2 == '0)) ? '0 : r_mem[read_port_2];

    assign read_data_1 = r_rd1;
    assign read_data_2 = r_rd2;
    assign rd_valid    = r_rd_valid;
    assign err         = r_err;

    // State register; reset aborts any clear in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: enter CLEAR on an accepted clear, leave after the last row.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (req_op == c_op_clear)) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (r_cnt == c_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Clear row counter; wraps back to 0 after the last row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_cnt <= r_cnt + ADDR_W'(1);
        end else if (w_accept && (req_op == c_op_clear)) begin
            r_cnt <= '0;
        end
    end

    // Register array: one row per clear cycle, or a single write in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == ST_CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_en) begin
            r_mem[write_port_1] <= write_data;
        end
    end

    // Registered read ports with a one-cycle valid pulse and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= w_accept && (req_op == c_op_read);
            r_err      <= w_accept && ((req_op == c_op_ill) ||
                                       ((req_op == c_op_write) && w_zero_wr));
            if (w_accept && (req_op == c_op_read)) begin
                r_rd1 <= w_rd1;
                r_rd2 <= w_rd2;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_param
// Description : Directed self-checking bench for reg_file_param. Two
//               instances share stimulus: one without and one with the
//               hardwired zero register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_op = 2'b00;
    logic [2:0] read_port_1 = '0;
    logic [2:0] read_port_2 = '0;
    logic [2:0] write_port_1 = '0;
    logic [7:0] write_data = '0;

    logic       req_ready, rd_valid, busy, err;
    logic [7:0] read_data_1, read_data_2;
    logic       z_req_ready, z_rd_valid, z_busy, z_err;
    logic [7:0] z_read_data_1, z_read_data_2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .read_port_1(read_port_1), .read_port_2(read_port_2),
        .write_port_1(write_port_1), .write_data(write_data),
        .read_data_1(read_data_1), .read_data_2(read_data_2),
        .rd_valid(rd_valid), .busy(busy), .err(err)
    );

    reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(z_req_ready),
        .req_op(req_op), .read_port_1(read_port_1), .read_port_2(read_port_2),
        .write_port_1(write_port_1), .write_data(write_data),
        .read_data_1(z_read_data_1), .read_data_2(z_read_data_2),
        .rd_valid(z_rd_valid), .busy(z_busy), .err(z_err)
    );

    // Present one request, let one edge pass, sample 1 time unit later.
    task automatic issue(input logic [1:0] op, input logic [2:0] a1, input logic [2:0] a2,
                         input logic [2:0] wa, input logic [7:0] wd);
        req_valid    = 1'b1;
        req_op       = op;
        read_port_1  = a1;
        read_port_2  = a2;
        write_port_1 = wa;
        write_data   = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({read_data_1, read_data_2, rd_valid, busy, err, req_ready} !== {8'h00, 8'h00, 4'b0001}) begin
            n_fail++;
            $display("FAIL reset_state: got rd1=%h rd2=%h v=%b b=%b e=%b rdy=%b want 00 00 0 0 0 1",
                     read_data_1, read_data_2, rd_valid, busy, err, req_ready);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        issue(2'b00, 3'd3, 3'd5, 3'd0, 8'h00);
        n_cmp++;
        if ({read_data_1, read_data_2, rd_valid} !== {8'h00, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_read: got %h %h v=%b want 00 00 v=1", read_data_1, read_data_2, rd_valid);
        end
        idle_cycle();
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_read_pulse: rd_valid=%b want 0", rd_valid);
        end
    endtask

    task automatic test_write_read();
        issue(2'b01, 3'd0, 3'd0, 3'd3, 8'hA5);
        n_cmp++;
        if ({rd_valid, read_data_1, read_data_2} !== {1'b0, 8'h00, 8'h00}) begin
            n_fail++;
            $display("FAIL write1_hold: got v=%b %h %h want v=0 00 00", rd_valid, read_data_1, read_data_2);
        end
        issue(2'b01, 3'd0, 3'd0, 3'd5, 8'h3C);
        issue(2'b00, 3'd3, 3'd5, 3'd0, 8'h00);
        n_cmp++;
        if ({read_data_1, read_data_2, rd_valid} !== {8'hA5, 8'h3C, 1'b1}) begin
            n_fail++;
            $display("FAIL write_read: got %h %h v=%b want a5 3c v=1", read_data_1, read_data_2, rd_valid);
        end
        idle_cycle();
        n_cmp++;
        if ({read_data_1, read_data_2, rd_valid} !== {8'hA5, 8'h3C, 1'b0}) begin
            n_fail++;
            $display("FAIL no_request_hold: got %h %h v=%b want a5 3c v=0", read_data_1, read_data_2, rd_valid);
        end
        issue(2'b01, 3'd0, 3'd0, 3'd1, 8'h11);
        n_cmp++;
        if ({read_data_1, read_data_2, rd_valid, err} !== {8'hA5, 8'h3C, 2'b00}) begin
            n_fail++;
            $display("FAIL write2_hold: got %h %h v=%b e=%b want a5 3c v=0 e=0",
                     read_data_1, read_data_2, rd_valid, err);
        end
    endtask

    task automatic test_back_to_back();
        issue(2'b01, 3'd0, 3'd0, 3'd6, 8'h7E);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: req_ready=%b want 1", req_ready);
        end
        issue(2'b00, 3'd6, 3'd6, 3'd0, 8'h00);
        n_cmp++;
        if ({read_data_1, read_data_2, rd_valid, req_ready} !== {8'h7E, 8'h7E, 2'b11}) begin
            n_fail++;
            $display("FAIL same_addr_read: got %h %h v=%b rdy=%b want 7e 7e 1 1",
                     read_data_1, read_data_2, rd_valid, req_ready);
        end
        issue(2'b00, 3'd1, 3'd5, 3'd0, 8'h00);
        n_cmp++;
        if ({read_data_1, read_data_2, rd_valid} !== {8'h11, 8'h3C, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_read: got %h %h v=%b want 11 3c 1", read_data_1, read_data_2, rd_valid);
        end
    endtask

    task automatic test_clear();
        int cnt;
        for (int i = 0; i < 8; i++) issue(2'b01, 3'd0, 3'd0, 3'(i), 8'hFF);
        issue(2'b00, 3'd0, 3'd7, 3'd0, 8'h00);
        n_cmp++;
        if ({read_data_1, read_data_2} !== {8'hFF, 8'hFF}) begin
            n_fail++;
            $display("FAIL fill: got %h %h want ff ff", read_data_1, read_data_2);
        end
        issue(2'b10, 3'd0, 3'd0, 3'd0, 8'h00);
        // hold a read pending through the clear
        req_valid = 1'b1; req_op = 2'b00; read_port_1 = 3'd0; read_port_2 = 3'd7;
        cnt = 0;
        while (busy === 1'b1 && cnt < 20) begin
            cnt++;
            n_cmp++;
            if ({req_ready, rd_valid, err} !== 3'b000) begin
                n_fail++;
                $display("FAIL clear_stall: cycle %0d rdy=%b v=%b e=%b want 0 0 0", cnt, req_ready, rd_valid, err);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (cnt !== 8) begin
            n_fail++;
            $display("FAIL clear_busy_len: got %0d cycles want 8", cnt);
        end
        n_cmp++;
        if ({req_ready, rd_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL clear_done: rdy=%b v=%b want 1 0", req_ready, rd_valid);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_cmp++;
        if ({read_data_1, read_data_2, rd_valid} !== {8'h00, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL pending_read: got %h %h v=%b want 00 00 1", read_data_1, read_data_2, rd_valid);
        end
        issue(2'b00, 3'd3, 3'd4, 3'd0, 8'h00);
        n_cmp++;
        if ({read_data_1, read_data_2} !== {8'h00, 8'h00}) begin
            n_fail++;
            $display("FAIL clear_mid_rows: got %h %h want 00 00", read_data_1, read_data_2);
        end
    endtask

    task automatic test_zero_reg_and_illegal();
        issue(2'b01, 3'd0, 3'd0, 3'd0, 8'h55);
        n_cmp++;
        if ({err, z_err} !== 2'b01) begin
            n_fail++;
            $display("FAIL zero_write_err: err=%b zerr=%b want 0 1", err, z_err);
        end
        issue(2'b00, 3'd0, 3'd0, 3'd0, 8'h00);
        n_cmp++;
        if ({read_data_1, read_data_2, z_read_data_1, z_read_data_2, z_err} !== {8'h55, 8'h55, 8'h00, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL zero_read: got %h %h z=%h %h zerr=%b want 55 55 z=00 00 0",
                     read_data_1, read_data_2, z_read_data_1, z_read_data_2, z_err);
        end
        issue(2'b01, 3'd0, 3'd0, 3'd4, 8'h44);
        issue(2'b11, 3'd4, 3'd4, 3'd4, 8'h99);
        n_cmp++;
        if ({err, z_err, rd_valid, read_data_1} !== {3'b110, 8'h55}) begin
            n_fail++;
            $display("FAIL illegal_op: err=%b zerr=%b v=%b rd1=%h want 1 1 0 55", err, z_err, rd_valid, read_data_1);
        end
        issue(2'b00, 3'd4, 3'd4, 3'd0, 8'h00);
        n_cmp++;
        if ({read_data_1, z_read_data_2, err} !== {8'h44, 8'h44, 1'b0}) begin
            n_fail++;
            $display("FAIL illegal_unchanged: got %h z=%h e=%b want 44 44 0", read_data_1, z_read_data_2, err);
        end
    endtask

    task automatic test_reset_mid_clear();
        issue(2'b01, 3'd0, 3'd0, 3'd5, 8'h3C);
        issue(2'b10, 3'd0, 3'd0, 3'd0, 8'h00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_clear_busy: busy=%b want 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, req_ready, read_data_1, read_data_2} !== {2'b01, 8'h00, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_abort: busy=%b rdy=%b rd=%h %h want 0 1 00 00",
                     busy, req_ready, read_data_1, read_data_2);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        issue(2'b01, 3'd0, 3'd0, 3'd2, 8'h12);
        issue(2'b00, 3'd2, 3'd5, 3'd0, 8'h00);
        n_cmp++;
        if ({read_data_1, read_data_2, rd_valid} !== {8'h12, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL post_reset_rw: got %h %h v=%b want 12 00 1", read_data_1, read_data_2, rd_valid);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_clear();
        test_zero_reg_and_illegal();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor to the team's 8x8 register file.
- Configurable data width and depth, with two read ports and one write port.
- Requests use a valid/ready handshake. Each request is exactly one kind: read, write or clear. Reads are registered.
- Adds an optional hardwired-zero register 0 and a sequential soft-clear engine. Sits between the datapath decode stage and the ALU operand latches.

Parameters:
- DATA_W, 8, bits per register.
- ADDR_W, 3, address bits; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 0: when 1, register 0 always reads 0 and writes to it are dropped.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_op  input  2  00 = read, 01 = write, 10 = clear, 11 = illegal.
- read_port_1  input  ADDR_W  read address, port 1.
- read_port_2  input  ADDR_W  read address, port 2.
- write_port_1  input  ADDR_W  write address.
- write_data  input  DATA_W  write data.
- read_data_1  output  DATA_W  registered read data, port 1.
- read_data_2  output  DATA_W  registered read data, port 2.
- rd_valid  output  1  one-cycle pulse when read_data_1/read_data_2 are updated.
- busy  output  1  clear engine running.
- err  output  1  one-cycle pulse on an illegal op, or on a write to reg 0 when ZERO_REG=1.

Behaviour:
- Reset (async assert, applied immediately):
  - all DEPTH registers = 0; read_data_1 = read_data_2 = 0;
  - rd_valid = 0, err = 0, busy = 0;
  - FSM = IDLE, clear counter = 0.
  - Reset asserted mid-clear aborts the clear; the array is zero anyway.
- FSM states: IDLE, CLEAR.
- IDLE:
  - req_ready = 1; a request is accepted on a rising edge with req_valid=1.
- Read (op 00):
  - At the accepting edge, read_data_1 <= reg[read_port_1] and read_data_2 <= reg[read_port_2]; rd_valid = 1 for the following cycle.
  - Latency is 1 clock. Both ports may use the same address and return identical data.
- Write (op 01):
  - reg[write_port_1] <= write_data at the accepting edge; rd_valid stays 0.
  - read_data_1/read_data_2 hold their previous values.
  - A read accepted on the next cycle sees the new value. No bypass is needed because ops are mutually exclusive.
- ZERO_REG=1:
  - A write to address 0 is dropped and err pulses for 1 cycle.
  - Reads of address 0 return 0 regardless of array contents.
- Clear (op 10):
  - At the accepting edge: FSM -> CLEAR, counter = 0, busy = 1, req_ready = 0.
  - Each CLEAR cycle: reg[counter] <= 0, counter++.
  - After the edge that clears reg[DEPTH-1]: FSM -> IDLE, busy = 0.
  - busy is high for exactly DEPTH cycles; counter wraps to 0.
  - In CLEAR, req_valid is ignored (no accept, no err). The requester must hold the request until req_ready=1.
- Illegal (op 11):
  - Accepted (consumes the handshake); no array or output change except an err pulse for 1 cycle.
- No request: req_valid=0 in IDLE leaves read data held and rd_valid = 0.
- Back-to-back requests are accepted every cycle in IDLE, with full throughput for read and write.
- Data inputs are sampled only at the accepting edge. write_data is truncated and extended only by its DATA_W declaration; no arithmetic is performed.
- Every register write, including clear, completes in the same edge; there are no partial writes.

Test Plan:
- Reset then read: rst pulse, then read 3,5 -> read_data_1=0x00, read_data_2=0x00, rd_valid high for 1 cycle after the accept edge.
- Write/read: write 0xA5 to 3 and 0x3C to 5 on consecutive cycles, then read 3,5 -> 0xA5 and 0x3C one cycle later. The write cycles give rd_valid=0 and hold read data.
- Same-address dual read and back-to-back mix: write 0x7E to 6, then read 6,6 in the next cycle -> both ports 0x7E, with no stall (req_ready stays 1).
- Clear engine:
  - Fill all 8 registers with 0xFF, issue clear -> busy=1 and req_ready=0 for exactly 8 cycles.
  - A read held pending during clear is accepted on the first cycle req_ready=1 and returns 0x00,0x00.
- ZERO_REG=1 and illegal op:
  - Write 0x55 to 0 -> err pulse, read 0 returns 0x00.
  - op=11 -> err pulse, array unchanged.
- Reset mid-clear: assert rst 3 cycles into a clear -> busy=0 and FSM in IDLE immediately, all registers 0. A subsequent write/read of 0x12 at address 2 works.
